br_multi: RTL and testbench

- Parametrised successor to the single-write, dual-read register bank in the rv32i datapath.
- Provides configurable width and depth, NRD read ports and two write ports with deterministic priority.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Sequential soft-clear engine zeroes the array one entry per cycle under a req/busy/done handshake; used by the core for context reset without a global reset.

---
 rtl/br_pkg.sv | 14 +
 rtl/br_clr_fsm.sv | 62 ++++++
 rtl/br_multi.sv | 79 +++++++
 tb/tb_br_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared definitions for the multi-port register bank: soft-clear FSM state
// encoding and default geometry.
package br_pkg;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_CLEAR = 2'd1,
    BR_DONE  = 2'd2
  } br_state_e;

  localparam int unsigned BR_XLEN = 32;
  localparam int unsigned BR_NREG = 32;

endpackage

// File: rtl/br_clr_fsm.sv
// Soft-clear sequencer: walks idx from 0 to NREG-1, one entry per cycle,
// under a req/busy/done handshake.
module br_clr_fsm
  import br_pkg::*;
#(
  parameter int unsigned NREG = BR_NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          idle,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  br_state_e     state;
  logic [AW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BR_IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        BR_IDLE: begin
          if (clr_req) begin
            state    <= BR_CLEAR;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        BR_CLEAR: begin
          // idx holds at LAST on exit instead of wrapping; next sweep reloads 0
          if (idx == LAST) begin
            state    <= BR_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        BR_DONE: begin
          state    <= BR_IDLE;
          clr_done <= 1'b0;
        end
        default: state <= BR_IDLE;
      endcase
    end
  end

  assign idle     = (state == BR_IDLE);
  assign clr_en   = (state == BR_CLEAR);
  assign clr_addr = idx;

endmodule

// File: rtl/br_multi.sv
// Parametrised register bank: NRD combinational read ports, two prioritised
// write ports, optional hardwired r0, optional write bypass, soft clear.
module br_multi
  import br_pkg::*;
#(
  parameter int unsigned XLEN    = BR_XLEN,
  parameter int unsigned NREG    = BR_NREG,
  parameter int unsigned AW      = $clog2(NREG),
  parameter int unsigned NRD     = 2,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  logic [XLEN-1:0] mem [NREG];
  logic            idle;
  logic            clr_en;
  logic [AW-1:0]   clr_addr;
  logic            wr0_ok;
  logic            wr1_ok;

  br_clr_fsm #(.NREG(NREG), .AW(AW)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .idle     (idle),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // Port 1 wins an address collision, so port 0 is suppressed outright.
  assign wr0_ok = we0 && !(we1 && (wa1 == wa0)) && !(ZERO_R0 && (wa0 == '0));
  assign wr1_ok = we1 && !(ZERO_R0 && (wa1 == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (idle) begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = ra[g*AW +: AW];

    always_comb begin
      data = mem[addr];
      if (BYPASS && idle) begin
        if (we1 && (wa1 == addr))      data = wd1;
        else if (we0 && (wa0 == addr)) data = wd0;
      end
      if (ZERO_R0 && (addr == '0)) data = '0;
    end

    assign rd[g*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_br_multi.sv
// Directed bench for br_multi: bypassing and non-bypassing instances share
// stimulus; expectations are queued at drive time and drained at sample time.
module tb_br_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ra;
  logic [63:0] rd, rd_nb;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        clr_req;
  logic        clr_busy, clr_done, busy_nb, done_nb;

  always #5 clk = ~clk;

  br_multi #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  br_multi #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_nb),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb)
  );

  typedef struct {
    string       tag;
    int unsigned kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  function automatic logic [31:0] observe(int unsigned kind);
    case (kind)
      0: return rd[31:0];
      1: return rd[63:32];
      2: return {31'b0, clr_busy};
      3: return {31'b0, clr_done};
      4: return rd_nb[31:0];
      5: return rd_nb[63:32];
      default: return 'x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned kind, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int unsigned a, input logic [31:0] d);
    we0 = 1'b1; wa0 = 5'(a); wd0 = d;
    step();
    we0 = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  initial begin
    int unsigned busy_cnt, done_cnt, done_at, bad;

    rst_n = 1'b0; clr_req = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra = {5'd31, 5'd7};
    for (int i = 0; i < 32; i++) model[i] = '0;

    // reset then read
    repeat (2) step();
    rst_n = 1'b1;
    push("rst_rd0", 0, 32'h0); push("rst_rd1", 1, 32'h0);
    push("rst_busy", 2, 32'h0); push("rst_done", 3, 32'h0);
    drain();

    // dual write, distinct then colliding addresses
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA_0001;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h5555_0002;
    step();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1111_0000;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2222_0000;
    step();
    we0 = 1'b0; we1 = 1'b0;
    model[3] = 32'hAAAA_0001; model[4] = 32'h5555_0002; model[9] = 32'h2222_0000;
    ra = {5'd4, 5'd3};
    push("dual_r3", 0, model[3]); push("dual_r4", 1, model[4]);
    drain();
    ra = {5'd9, 5'd9};
    push("collide_r9", 0, model[9]); push("collide_r9_nb", 5, model[9]);
    drain();

    // hardwired zero register
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; ra = {5'd0, 5'd0};
    push("r0_same", 0, 32'h0); push("r0_same_nb", 4, 32'h0);
    drain();
    step();
    we1 = 1'b0;
    push("r0_after", 0, 32'h0); push("r0_after_nb", 5, 32'h0);
    drain();

    // bypass, then bypass priority
    wr0(5, 32'h0000_1234);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_BEEF; ra = {5'd3, 5'd5};
    push("byp_same", 0, 32'h0000_BEEF); push("nobyp_same", 4, 32'h0000_1234);
    push("byp_other_port", 1, model[3]);
    drain();
    step();
    we0 = 1'b0;
    push("byp_after", 0, 32'h0000_BEEF); push("nobyp_after", 4, 32'h0000_BEEF);
    drain();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_1111;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h0000_2222;
    push("byp_prio", 0, 32'h0000_2222); push("nobyp_prio", 4, 32'h0000_BEEF);
    drain();
    step();
    we0 = 1'b0; we1 = 1'b0;
    model[5] = 32'h0000_2222;
    push("prio_after", 0, model[5]);
    drain();

    // soft clear sweep
    for (int unsigned i = 1; i < 32; i++) wr0(i, (i * 32'h0101_0101) + 32'h10);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_at = k; end
      if (k == 5) begin
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hDEAD_BEEF; ra = {5'd20, 5'd2};
        push("mid_r2_cleared", 0, 32'h0); push("mid_r20_kept", 1, model[20]);
        drain();
      end
      if (k == 6) we0 = 1'b0;
      step();
    end
    check("busy_cycles", busy_cnt, 32);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_at, 32);
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      ra = {5'(i), 5'(i)};
      push("swept", 0, model[i]); push("swept_nb", 5, model[i]);
      drain();
      step();
    end

    // reset mid-sweep
    wr0(31, 32'h3131_3131);
    wr0(7, 32'h0000_0077);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    push("sweep_busy", 2, 32'h1);
    drain();
    rst_n = 1'b0; ra = {5'd31, 5'd7};
    for (int i = 0; i < 32; i++) model[i] = '0;
    push("rst_mid_busy", 2, 32'h0); push("rst_mid_done", 3, 32'h0);
    push("rst_mid_r7", 0, model[7]); push("rst_mid_r31", 1, model[31]);
    drain();
    repeat (2) step();
    rst_n = 1'b1;
    bad = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      if (clr_busy || clr_done) bad++;
      step();
    end
    check("post_rst_quiet", bad, 0);
    wr0(6, 32'h0000_0066);
    ra = {5'd31, 5'd6};
    push("post_rst_wr", 0, model[6]); push("post_rst_wr_nb", 4, model[6]);
    push("post_rst_r31", 1, model[31]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
